inst_fetch_buffer: RTL
======================

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of instruction queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 start  input  1  reset, asynchronous, active-low: start=0 resets the block, start=1 runs it.
REQ-005 redirect  input  1  taken branch or jump resolved in ID.
REQ-006 redirect_pc  input  32  target address, valid when redirect=1.
REQ-007 stall  input  1  decode cannot accept (IF/ID write disabled).
REQ-008 imem_req  output  1  fetch request; always accepted in the cycle it is high.
REQ-009 imem_addr  output  32  fetch address, valid when imem_req=1.
REQ-010 imem_valid  input  1  response strobe, 1 or more cycles after the request, in order.
REQ-011 imem_data  input  32  instruction word, valid when imem_valid=1.
REQ-012 out_valid  output  1  out_pc/out_inst hold a valid instruction for IF/ID.
REQ-013 out_pc  output  32  PC of the head entry.
REQ-014 out_inst  output  32  instruction of the head entry.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (one request outstanding), DISCARD (one stale request outstanding); at most one request is outstanding at any time.
REQ-016 imem_req SHALL be combinational: 1 iff state=IDLE, count<DEPTH and redirect=0; imem_addr=fetch_pc.
REQ-017 On an issued request: fetch_pc<=fetch_pc+4 (32-bit wrap) and IDLE->WAIT.
REQ-018 In WAIT with imem_valid=1 and redirect=0: push {issued pc, imem_data} into the queue, go to IDLE.
REQ-019 Pop SHALL occur when out_valid=1 and stall=0; the head entry advances at that edge.
REQ-020 Push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-021 The count<DEPTH issue rule SHALL guarantee that a push never finds the queue full; pop on empty SHALL be a no-op.
REQ-022 Redirect SHALL have priority over push, pop and stall.
REQ-023 On redirect, at the edge: flush the queue (count=0), set fetch_pc<=redirect_pc, and take the next state from REQ-024.
REQ-024 Next state on redirect: WAIT with imem_valid=0 -> DISCARD; WAIT with imem_valid=1 -> IDLE, response dropped; DISCARD -> stays DISCARD; IDLE -> IDLE.
REQ-025 In DISCARD, imem_valid=1 SHALL drop the response and move to IDLE.
REQ-026 Without bypass, out_valid=(count!=0), giving a one-cycle minimum latency from imem_valid to out_valid.
REQ-027 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 start=0 SHALL asynchronously force state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC and out_valid=0.
REQ-029 When start=0, out_pc and out_inst SHALL be 0, and a response arriving during or right after reset SHALL be ignored.
REQ-030 The first request SHALL be issued in the first cycle after start rises, with imem_addr=RESET_PC.

Configuration
REQ-031 Macro IFB_BYPASS_EN, defined: when count=0, state=WAIT, imem_valid=1 and redirect=0, out_valid=1 with out_inst=imem_data and out_pc=the issued pc in the same cycle.
REQ-032 With IFB_BYPASS_EN, the entry is not stored if stall=0, and is pushed if stall=1.
REQ-033 IFB_BYPASS_EN undefined: no combinational path from imem_* to out_*; REQ-026 applies.

Verification
REQ-034 Reset, then 1-cycle memory, stall=0: requests go to 0x0,0x4,0x8; out_pc sequence is 0x0,0x4,0x8, each with its matching instruction.
REQ-035 stall=1 held for 10 cycles, DEPTH=4: exactly 4 entries are queued, imem_req=0 thereafter, and out_pc stays 0x0 until stall drops.
REQ-036 redirect to 0x100 while in WAIT, with the response arriving 2 cycles later: that response is dropped, the next request goes to 0x100, and the next out_pc is 0x100.
REQ-037 redirect and imem_valid in the same cycle: the response is dropped, the queue is empty, and imem_req to redirect_pc follows in the next cycle.
REQ-038 start pulsed low mid-run with 3 queued entries: out_valid=0 immediately (asynchronous), and the first request after release goes to RESET_PC.
REQ-039 With IFB_BYPASS_EN, empty queue, imem_valid carrying 0x00500093: out_valid=1 and out_inst=0x00500093 in the same cycle; without the macro, they appear one cycle later.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
// Instruction fetch unit with a small in-order instruction queue feeding the
// IF/ID stage. At most one memory request is in flight. A redirect flushes the
// queue, and a response that is still outstanding is marked stale (DISCARD).
//
// Optional build macro: IFB_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is presented on out_* in the same cycle.
//
// Parameters
//   DEPTH       queue entries (power of two, 2..16)
//   RESET_PC    first fetch address after reset
// Ports
//   clk          clock
//   start        asynchronous active-low reset (0 = reset, 1 = run)
//   redirect     taken branch/jump from ID; redirect_pc is its target
//   stall        decode cannot accept the head entry
//   imem_req     fetch request (combinational), imem_addr is its address
//   imem_valid   in-order response strobe, imem_data is the instruction word
//   out_valid    head entry valid; out_pc/out_inst are its PC and instruction
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        start,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_t             state;
   state_t             state_nxt;
   logic [31:0]        fetch_pc;
   logic [31:0]        req_pc;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   entry_t             mem [DEPTH];

   logic               q_nempty;
   logic               issue;
   logic               resp_take;
   logic               push;
   logic               pop;
   entry_t             head;

   assign q_nempty  = (count != '0);
   assign head      = mem[rd_ptr];

   // Gated by start so no request is shown while the block is held in reset.
   assign issue     = start && (state == IDLE) && (count < CNT_W'(DEPTH)) && !redirect;
   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   assign resp_take = (state == WAIT) && imem_valid && !redirect;
   assign pop       = q_nempty && !stall && !redirect;

`ifdef IFB_BYPASS_EN
   logic bypass;

   // Empty queue: forward the response directly; store it only if decode stalls.
   assign bypass    = resp_take && !q_nempty;
   assign push      = resp_take && !(bypass && !stall);
   assign out_valid = q_nempty || bypass;
   assign out_pc    = q_nempty ? head.pc   : (bypass ? req_pc    : 32'h0);
   assign out_inst  = q_nempty ? head.inst : (bypass ? imem_data : 32'h0);
`else
   assign push      = resp_take;
   assign out_valid = q_nempty;
   assign out_pc    = q_nempty ? head.pc   : 32'h0;
   assign out_inst  = q_nempty ? head.inst : 32'h0;
`endif

   // State register.
   always_ff @(posedge clk or negedge start) begin
      if (!start) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: track the single outstanding request and whether it is stale.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (issue) state_nxt = WAIT;
         end
         WAIT: begin
            if (redirect)        state_nxt = imem_valid ? IDLE : DISCARD;
            else if (imem_valid) state_nxt = IDLE;
         end
         DISCARD: begin
            if (imem_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Fetch PC, issued PC, queue pointers and occupancy.
   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage; contents are only observed through count-qualified reads.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{pc: req_pc, inst: imem_data};
   end

endmodule
